// File: rtl/poly_coeff_sampler.sv
// -----------------------------------------------------------------------------
// poly_coeff_sampler
//
// Turns a stream of 64-bit PRNG words into polynomial coefficients. One run
// produces (npoly_m1+1) polynomials of 2^min(log_n, LOGN) coefficients each.
// The distribution is one of the following:
//   00 uniform mod q with rejection
//   01 centred binomial (sign-magnitude)
//   10 ternary with rejection
// Accepted coefficients pass through a 2-entry FIFO. Its head register drives
// out_*, so both the PRNG side and the RAM-writer side may stall.
//
// Optional feature, selected by a compile-time macro:
//   SAMPLER_REJECT_STATS_EN
//     defined   : reject_count is a saturating count of rejected words.
//     undefined : reject_count is tied to 0.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   start           start pulse, sampled only in IDLE
//   mode            distribution select (11 reserved, start ignored)
//   log_n           log2 of coefficients per polynomial, clamped to LOGN
//   npoly_m1        number of polynomials minus 1
//   q, shift        modulus and right shift for uniform mode
//   rnd_data        PRNG word; rnd_valid / rnd_ready form its handshake
//   out_coef        output coefficient
//   out_addr        coefficient index within its polynomial
//   out_poly        polynomial index
//   out_last        marks the final coefficient of the run
//   out_valid       output handshake, valid side
//   out_ready       output handshake, ready side
//   busy            high in RUN or DRAIN
//   done            one-cycle pulse when the run has fully drained
//   reject_count    rejected-word counter (see macro above)
// -----------------------------------------------------------------------------
module poly_coeff_sampler #(
    parameter int LOGN    = 13,
    parameter int LOGQ    = 54,
    parameter int ETA     = 21,
    parameter int NPOLY_W = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         mode,
    input  logic [3:0]         log_n,
    input  logic [NPOLY_W-1:0] npoly_m1,
    input  logic [LOGQ-1:0]    q,
    input  logic [5:0]         shift,
    input  logic [63:0]        rnd_data,
    input  logic               rnd_valid,
    output logic               rnd_ready,
    output logic [LOGQ-1:0]    out_coef,
    output logic [LOGN-1:0]    out_addr,
    output logic [NPOLY_W-1:0] out_poly,
    output logic               out_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               busy,
    output logic               done,
    output logic [31:0]        reject_count
);

    localparam int EW = $clog2(ETA + 1) + 1;  // CBD sign-magnitude width
    localparam int PW = EW - 1;               // popcount / magnitude width
    localparam logic [3:0]      LOGN_CLAMP = (LOGN > 15) ? 4'd15 : 4'(LOGN);
    localparam logic [LOGN-1:0] ADDR_ONES  = '1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;
    typedef enum logic [1:0] {
        M_UNIFORM = 2'b00, M_CBD = 2'b01, M_TERNARY = 2'b10, M_RESERVED = 2'b11
    } mode_t;

    typedef struct packed {
        logic [LOGQ-1:0]    coef;
        logic [LOGN-1:0]    addr;
        logic [NPOLY_W-1:0] poly;
        logic               last;
    } entry_t;

    state_t             r_state, w_next_state;
    mode_t              r_mode;
    logic [3:0]         r_log_n;
    logic [NPOLY_W-1:0] r_npoly_m1;
    logic [LOGQ-1:0]    r_q;
    logic [5:0]         r_shift;
    logic [LOGN-1:0]    r_addr;
    logic [NPOLY_W-1:0] r_poly;
    entry_t             r_fifo [2];
    logic               r_wr_ptr, r_rd_ptr;
    logic [1:0]         r_count;
    logic               r_done;

    logic               w_start_ok, w_accept, w_push, w_pop, w_at_end, w_last_push;
    logic [LOGN-1:0]    w_addr_max;
    logic [LOGQ-1:0]    w_uni, w_coef;
    logic [PW-1:0]      w_pop_a, w_pop_b, w_mag;
    logic               w_sign, w_reject;
    logic [15:0]        w_s;

    // ---------------- handshakes (rnd_ready depends on registers only) -------
    assign rnd_ready  = (r_state == S_RUN) && (r_count != 2'd2);
    assign out_valid  = (r_count != 2'd0);
    assign busy       = (r_state != S_IDLE);
    assign done       = r_done;
    assign w_accept   = rnd_valid && rnd_ready;
    assign w_push     = w_accept && !w_reject;
    assign w_pop      = out_valid && out_ready;
    assign w_start_ok = (r_state == S_IDLE) && start && (mode != M_RESERVED);

    // Mask of the low r_log_n bits gives the last index, 2^n - 1.
    assign w_addr_max  = ~(ADDR_ONES << r_log_n);
    assign w_at_end    = (r_addr == w_addr_max) && (r_poly == r_npoly_m1);
    assign w_last_push = w_push && w_at_end;

    // ---------------- candidate generation -----------------------------------
    assign w_uni = rnd_data[LOGQ-1:0] >> r_shift;
    assign w_s   = rnd_data[63:48];

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        w_pop_a = '0;
        w_pop_b = '0;
        // NOTE: blocking '=' is right here: the sum is built up step by step
        // within one evaluation. Clocked state below uses '<=' only.
        for (int i = 0; i < ETA; i++) begin
            w_pop_a = w_pop_a + PW'(rnd_data[i]);
            w_pop_b = w_pop_b + PW'(rnd_data[ETA + i]);
        end
        // Zero difference takes the non-negative branch, so zero has sign 0.
        w_sign = (w_pop_a < w_pop_b);
        w_mag  = w_sign ? (w_pop_b - w_pop_a) : (w_pop_a - w_pop_b);
    end

    always_comb begin
        w_coef   = '0;
        w_reject = 1'b0;
        case (r_mode)
            M_UNIFORM: begin
                w_coef   = w_uni;
                w_reject = (w_uni >= r_q);
            end
            M_CBD: begin
                w_coef[EW-1]   = w_sign;
                w_coef[PW-1:0] = w_mag;
            end
            M_TERNARY: begin
                w_reject = (w_s == 16'hffff);
                if (w_s < 16'h5555)      w_coef = LOGQ'(0);
                else if (w_s < 16'haaaa) w_coef = LOGQ'(1);
                else                     w_coef = LOGQ'(3);
            end
            default: w_reject = 1'b1;
        endcase
    end

    // ---------------- FSM ----------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_start_ok)       w_next_state = S_RUN;
            S_RUN:   if (w_last_push)      w_next_state = S_DRAIN;
            S_DRAIN: if (r_count == 2'd0)  w_next_state = S_IDLE;
            default:                       w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_done <= 1'b0;
        else     r_done <= (r_state == S_DRAIN) && (r_count == 2'd0);
    end

    // ---------------- run configuration and index counters -------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode     <= M_UNIFORM;
            r_log_n    <= '0;
            r_npoly_m1 <= '0;
            r_q        <= '0;
            r_shift    <= '0;
            r_addr     <= '0;
            r_poly     <= '0;
        end else if (w_start_ok) begin
            r_mode     <= mode_t'(mode);
            r_log_n    <= (log_n > LOGN_CLAMP) ? LOGN_CLAMP : log_n;
            r_npoly_m1 <= npoly_m1;
            r_q        <= q;
            r_shift    <= shift;
            r_addr     <= '0;
            r_poly     <= '0;
        end else if (w_push) begin
            if (r_addr == w_addr_max) begin
                r_addr <= '0;
                r_poly <= r_poly + 1'b1;
            end else begin
                r_addr <= r_addr + 1'b1;
            end
        end
    end

    // ---------------- 2-entry output FIFO ------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the two storage entries are reset as well. They feed
            // out_* directly, and those outputs must read 0 during reset.
            r_fifo[0] <= '0;
            r_fifo[1] <= '0;
            r_wr_ptr  <= 1'b0;
            r_rd_ptr  <= 1'b0;
            r_count   <= 2'd0;
        end else begin
            if (w_push) begin
                r_fifo[r_wr_ptr] <= '{coef: w_coef, addr: r_addr, poly: r_poly, last: w_at_end};
                r_wr_ptr         <= ~r_wr_ptr;
            end
            if (w_pop) r_rd_ptr <= ~r_rd_ptr;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign out_coef = r_fifo[r_rd_ptr].coef;
    assign out_addr = r_fifo[r_rd_ptr].addr;
    assign out_poly = r_fifo[r_rd_ptr].poly;
    assign out_last = r_fifo[r_rd_ptr].last;

    // ---------------- optional rejection statistics --------------------------
`ifdef SAMPLER_REJECT_STATS_EN
    logic [31:0] r_reject_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                                r_reject_count <= '0;
        else if (w_start_ok)                                    r_reject_count <= '0;
        else if (w_accept && w_reject && (r_reject_count != '1)) r_reject_count <= r_reject_count + 32'd1;
    end

    assign reject_count = r_reject_count;
`else
    assign reject_count = 32'd0;
`endif

endmodule
